pbkdf2_block_collector: RTL and testbench

Iteration controller and output assembler directly downstream of the 212-byte HMAC-SHA256 stage in the scrypt PBKDF2 path. It issues one HMAC request per PBKDF2 block index i = 1..NUM_BLOCKS, and supplies `block_index` so the upstream message formatter can append INT(i). It captures each 256-bit `hash` on `hash_done` and concatenates the results into the 1024-bit B vector consumed by the scrypt mixing core. Output is handed off with a valid/ready handshake.

---
 rtl/pbkdf2_block_collector.sv | 144 ++++++++++++++
 tb/tb_pbkdf2_block_collector.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pbkdf2_block_collector.sv
`timescale 1ns/1ps
// pbkdf2_block_collector
// Iteration controller and B-vector assembler for the scrypt PBKDF2 path.
// It requests one HMAC-SHA256 computation per block index i = 1..NUM_BLOCKS.
// It captures each 256-bit result into its slot, with block 1 in the MSBs.
// The finished B vector is handed off with a valid/ready handshake.
//
// Ports:
//   clk          in   rising-edge clock
//   n_rst        in   synchronous active-low reset
//   start        in   begin a new run (honoured only in IDLE)
//   hash         in   256-bit HMAC result
//   hash_done    in   single-cycle strobe, hash valid
//   b_ready      in   consumer accepts B while b_valid is high
//   hmac_enable  out  single-cycle pulse launching one HMAC computation
//   block_index  out  current 1-based block number, 0 when idle
//   busy         out  high from start acceptance until B is handed off
//   b_out        out  assembled B vector (256*NUM_BLOCKS bits)
//   b_valid      out  B complete and stable
module pbkdf2_block_collector #(
   parameter int NUM_BLOCKS = 4
) (
   input  logic                      clk,
   input  logic                      n_rst,
   input  logic                      start,
   input  logic [255:0]              hash,
   input  logic                      hash_done,
   input  logic                      b_ready,
   output logic                      hmac_enable,
   output logic [2:0]                block_index,
   output logic                      busy,
   output logic [256*NUM_BLOCKS-1:0] b_out,
   output logic                      b_valid
);

   localparam int BW = 256 * NUM_BLOCKS;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_WAIT  = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   localparam logic [2:0] LAST_INDEX = 3'(NUM_BLOCKS);

   logic [1:0]    state_r,       state_s;
   logic          hmac_enable_r, hmac_enable_s;
   logic [2:0]    block_index_r, block_index_s;
   logic          busy_r,        busy_s;
   logic [BW-1:0] b_out_r,       b_out_s;
   logic          b_valid_r,     b_valid_s;

   // Next-state and next-output computation for the run controller.
   always_comb begin
      state_s       = state_r;
      hmac_enable_s = 1'b0;
      block_index_s = block_index_r;
      busy_s        = busy_r;
      b_out_s       = b_out_r;
      b_valid_s     = b_valid_r;
      case (state_r)
         ST_IDLE: begin
            if (start) begin
               state_s       = ST_ISSUE;
               hmac_enable_s = 1'b1;
               block_index_s = 3'd1;
               busy_s        = 1'b1;
               b_out_s       = {BW{1'b0}};
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_ISSUE: begin
            // The request pulse is only ever one cycle wide.
            state_s = ST_WAIT;
         end
         ST_WAIT: begin
            if (hash_done) begin
               // Block k+1 lands in slot NUM_BLOCKS-1-k, so block 1 ends up in the MSBs.
               for (int k = 0; k < NUM_BLOCKS; k++) begin
                  if (block_index_r == 3'(k + 1)) begin
                     b_out_s[256*(NUM_BLOCKS-1-k) +: 256] = hash;
                  end else begin
                     b_out_s[256*(NUM_BLOCKS-1-k) +: 256] = b_out_r[256*(NUM_BLOCKS-1-k) +: 256];
                  end
               end
               if (block_index_r == LAST_INDEX) begin
                  state_s   = ST_DONE;
                  b_valid_s = 1'b1;
               end else begin
                  state_s       = ST_ISSUE;
                  hmac_enable_s = 1'b1;
                  block_index_s = block_index_r + 3'd1;
               end
            end else begin
               state_s = ST_WAIT;
            end
         end
         ST_DONE: begin
            // A start that coincides with acceptance is dropped on purpose.
            if (b_ready) begin
               state_s       = ST_IDLE;
               b_valid_s     = 1'b0;
               busy_s        = 1'b0;
               block_index_s = 3'd0;
            end else begin
               state_s = ST_DONE;
            end
         end
         default: begin
            state_s       = ST_IDLE;
            block_index_s = 3'd0;
            busy_s        = 1'b0;
            b_out_s       = {BW{1'b0}};
            b_valid_s     = 1'b0;
         end
      endcase
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!n_rst) begin
         state_r       <= ST_IDLE;
         hmac_enable_r <= 1'b0;
         block_index_r <= 3'd0;
         busy_r        <= 1'b0;
         b_out_r       <= {BW{1'b0}};
         b_valid_r     <= 1'b0;
      end else begin
         state_r       <= state_s;
         hmac_enable_r <= hmac_enable_s;
         block_index_r <= block_index_s;
         busy_r        <= busy_s;
         b_out_r       <= b_out_s;
         b_valid_r     <= b_valid_s;
      end
   end

   assign hmac_enable = hmac_enable_r;
   assign block_index = block_index_r;
   assign busy        = busy_r;
   assign b_out       = b_out_r;
   assign b_valid     = b_valid_r;

endmodule

// File: tb/tb_pbkdf2_block_collector.sv
`timescale 1ns/1ps
// Directed self-checking bench for pbkdf2_block_collector with NUM_BLOCKS = 4.
module tb_pbkdf2_block_collector;

   localparam int NB = 4;

   logic            clk;
   logic            n_rst;
   logic            start;
   logic [255:0]    hash;
   logic            hash_done;
   logic            b_ready;
   logic            hmac_enable;
   logic [2:0]      block_index;
   logic            busy;
   logic [256*NB-1:0] b_out;
   logic            b_valid;

   int checks;
   int errors;
   int pulse_cnt;
   int consec_cnt;
   logic prev_hmac;
   logic [256*NB-1:0] exp_b;
   logic [256*NB-1:0] zero_b;

   pbkdf2_block_collector #(.NUM_BLOCKS(NB)) dut (
      .clk         (clk),
      .n_rst       (n_rst),
      .start       (start),
      .hash        (hash),
      .hash_done   (hash_done),
      .b_ready     (b_ready),
      .hmac_enable (hmac_enable),
      .block_index (block_index),
      .busy        (busy),
      .b_out       (b_out),
      .b_valid     (b_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [255:0] pat(input int i);
      logic [3:0] n;
      n = 4'(i);
      return {64{n}};
   endfunction

   // Advance one edge, sample 1 ns later, and track request pulses.
   task automatic tick();
      @(posedge clk);
      #1;
      if (hmac_enable === 1'b1) pulse_cnt++;
      if (hmac_enable === 1'b1 && prev_hmac === 1'b1) consec_cnt++;
      prev_hmac = hmac_enable;
   endtask

   // Act as the HMAC stage for blocks first..last; the request for 'first' must be visible.
   task automatic serve_blocks(input int first, input int last, input bit inject_start);
      for (int blk = first; blk <= last; blk++) begin
         int w;
         w = 0;
         while (hmac_enable !== 1'b1 && w < 4) begin
            tick();
            w++;
         end
         checks++;
         if (hmac_enable !== 1'b1 || block_index !== 3'(blk)) begin
            errors++;
            $display("FAIL req_blk%0d: hmac_enable=%b block_index=%0d, required 1 and %0d",
                     blk, hmac_enable, block_index, blk);
         end
         tick();
         checks++;
         if (hmac_enable !== 1'b0) begin
            errors++;
            $display("FAIL pulse_width_blk%0d: hmac_enable=%b, required 0", blk, hmac_enable);
         end
         if (inject_start) start = 1'b1;
         for (int c = 0; c < 3; c++) tick();
         start     = 1'b0;
         hash      = pat(blk);
         hash_done = 1'b1;
         tick();
         hash_done = 1'b0;
         hash      = '0;
      end
   endtask

   task automatic test_reset();
      n_rst = 1'b0;
      start = 1'b1;
      for (int c = 0; c < 3; c++) tick();
      checks++;
      if (hmac_enable !== 1'b0 || block_index !== 3'd0 || busy !== 1'b0 || b_valid !== 1'b0 || b_out !== zero_b) begin
         errors++;
         $display("FAIL reset_outputs: en=%b idx=%0d busy=%b valid=%b b_out_zero=%b, required all 0",
                  hmac_enable, block_index, busy, b_valid, (b_out === zero_b));
      end
      n_rst = 1'b1;
      start = 1'b0;
      pulse_cnt = 0;
      for (int c = 0; c < 3; c++) tick();
      checks++;
      if (pulse_cnt != 0 || busy !== 1'b0 || block_index !== 3'd0) begin
         errors++;
         $display("FAIL idle_after_reset: pulses=%0d busy=%b idx=%0d, required 0 0 0", pulse_cnt, busy, block_index);
      end
   endtask

   task automatic test_spurious_idle();
      hash      = '1;
      hash_done = 1'b1;
      tick();
      hash_done = 1'b0;
      hash      = '0;
      tick();
      checks++;
      if (b_out !== zero_b || busy !== 1'b0 || block_index !== 3'd0 || hmac_enable !== 1'b0 || b_valid !== 1'b0) begin
         errors++;
         $display("FAIL idle_hash_done: busy=%b idx=%0d en=%b valid=%b b_out_zero=%b, required idle with zero B",
                  busy, block_index, hmac_enable, b_valid, (b_out === zero_b));
      end
   endtask

   task automatic test_nominal();
      pulse_cnt = 0;
      start = 1'b1;
      tick();
      start = 1'b0;
      checks++;
      if (busy !== 1'b1 || block_index !== 3'd1 || hmac_enable !== 1'b1) begin
         errors++;
         $display("FAIL start_accept: busy=%b idx=%0d en=%b, required 1 1 1", busy, block_index, hmac_enable);
      end
      serve_blocks(1, NB, 1'b0);
      checks++;
      if (b_valid !== 1'b1 || busy !== 1'b1) begin
         errors++;
         $display("FAIL nominal_valid: b_valid=%b busy=%b, required 1 1", b_valid, busy);
      end
      checks++;
      if (b_out !== exp_b) begin
         errors++;
         $display("FAIL nominal_b_out: got %h required %h", b_out, exp_b);
      end
      checks++;
      if (pulse_cnt != NB) begin
         errors++;
         $display("FAIL nominal_pulses: got %0d required %0d", pulse_cnt, NB);
      end
   endtask

   task automatic test_backpressure();
      int unstable;
      unstable = 0;
      pulse_cnt = 0;
      b_ready = 1'b0;
      for (int c = 0; c < 10; c++) begin
         if (c == 4) begin
            hash      = '1;
            hash_done = 1'b1;
         end
         tick();
         hash_done = 1'b0;
         hash      = '0;
         if (b_valid !== 1'b1 || b_out !== exp_b) unstable++;
      end
      checks++;
      if (unstable != 0 || pulse_cnt != 0) begin
         errors++;
         $display("FAIL backpressure_hold: unstable_cycles=%0d pulses=%0d, required 0 0", unstable, pulse_cnt);
      end
      b_ready = 1'b1;
      tick();
      b_ready = 1'b0;
      checks++;
      if (b_valid !== 1'b0 || busy !== 1'b0 || block_index !== 3'd0) begin
         errors++;
         $display("FAIL handoff: valid=%b busy=%b idx=%0d, required 0 0 0", b_valid, busy, block_index);
      end
      checks++;
      if (b_out !== exp_b) begin
         errors++;
         $display("FAIL b_out_retained: got %h required %h", b_out, exp_b);
      end
   endtask

   task automatic test_start_in_wait();
      pulse_cnt = 0;
      start = 1'b1;
      tick();
      start = 1'b0;
      serve_blocks(1, NB, 1'b1);
      checks++;
      if (pulse_cnt != NB || b_valid !== 1'b1 || b_out !== exp_b) begin
         errors++;
         $display("FAIL start_in_wait: pulses=%0d valid=%b b_out_ok=%b, required %0d 1 1",
                  pulse_cnt, b_valid, (b_out === exp_b), NB);
      end
   endtask

   task automatic test_back_to_back();
      pulse_cnt = 0;
      b_ready = 1'b1;
      start   = 1'b1;
      tick();
      b_ready = 1'b0;
      checks++;
      if (busy !== 1'b0 || hmac_enable !== 1'b0 || block_index !== 3'd0 || b_valid !== 1'b0) begin
         errors++;
         $display("FAIL start_at_accept: busy=%b en=%b idx=%0d valid=%b, required 0 0 0 0",
                  busy, hmac_enable, block_index, b_valid);
      end
      tick();
      start = 1'b0;
      checks++;
      if (busy !== 1'b1 || hmac_enable !== 1'b1 || block_index !== 3'd1 || b_out !== zero_b) begin
         errors++;
         $display("FAIL restart: busy=%b en=%b idx=%0d b_out_zero=%b, required 1 1 1 1",
                  busy, hmac_enable, block_index, (b_out === zero_b));
      end
   endtask

   task automatic test_reset_mid_run();
      serve_blocks(1, 1, 1'b0);
      checks++;
      if (hmac_enable !== 1'b1 || block_index !== 3'd2) begin
         errors++;
         $display("FAIL block2_req: en=%b idx=%0d, required 1 2", hmac_enable, block_index);
      end
      tick();
      tick();
      n_rst = 1'b0;
      tick();
      n_rst = 1'b1;
      checks++;
      if (hmac_enable !== 1'b0 || block_index !== 3'd0 || busy !== 1'b0 || b_valid !== 1'b0 || b_out !== zero_b) begin
         errors++;
         $display("FAIL mid_run_reset: en=%b idx=%0d busy=%b valid=%b b_out_zero=%b, required all 0",
                  hmac_enable, block_index, busy, b_valid, (b_out === zero_b));
      end
      hash      = pat(2);
      hash_done = 1'b1;
      tick();
      hash_done = 1'b0;
      hash      = '0;
      checks++;
      if (b_out !== zero_b || busy !== 1'b0) begin
         errors++;
         $display("FAIL late_hash_done: busy=%b b_out_zero=%b, required 0 1", busy, (b_out === zero_b));
      end
      pulse_cnt = 0;
      start = 1'b1;
      tick();
      start = 1'b0;
      checks++;
      if (block_index !== 3'd1 || hmac_enable !== 1'b1) begin
         errors++;
         $display("FAIL post_reset_start: idx=%0d en=%b, required 1 1", block_index, hmac_enable);
      end
      serve_blocks(1, NB, 1'b0);
      checks++;
      if (b_out !== exp_b || b_valid !== 1'b1 || pulse_cnt != NB) begin
         errors++;
         $display("FAIL post_reset_run: b_out_ok=%b valid=%b pulses=%0d, required 1 1 %0d",
                  (b_out === exp_b), b_valid, pulse_cnt, NB);
      end
      b_ready = 1'b1;
      tick();
      b_ready = 1'b0;
      checks++;
      if (b_valid !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL final_handoff: valid=%b busy=%b, required 0 0", b_valid, busy);
      end
   endtask

   initial begin
      checks     = 0;
      errors     = 0;
      pulse_cnt  = 0;
      consec_cnt = 0;
      prev_hmac  = 1'b0;
      zero_b     = '0;
      exp_b      = {pat(1), pat(2), pat(3), pat(4)};
      n_rst      = 1'b0;
      start      = 1'b0;
      hash       = '0;
      hash_done  = 1'b0;
      b_ready    = 1'b0;
      #2;

      test_reset();
      test_spurious_idle();
      test_nominal();
      test_backpressure();
      test_start_in_wait();
      test_back_to_back();
      test_reset_mid_run();

      checks++;
      if (consec_cnt != 0) begin
         errors++;
         $display("FAIL hmac_consecutive: got %0d back-to-back high cycles, required 0", consec_cnt);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
